// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_ctrl_if
//  Purpose  : Request/response bundle between a requesting master and the
//             nibble-serial adder sequencer.
//  Signals  : start     - request, honoured only while the sequencer is idle
//             sub       - 0: a+b+cin, 1: a-b (cin ignored)
//             a, b      - WIDTH-bit operands, sampled on accept
//             cin       - carry-in for add, sampled on accept
//             busy      - operation in flight (RUN or DONE)
//             done      - one-cycle result-valid pulse
//             sum       - registered result, held until the next done
//             carry     - carry out of the MSB (for sub: 1 = no borrow)
//             overflow  - signed two's-complement overflow
//  Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, carry, overflow
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_ctrl
//  Purpose  : WIDTH-bit add/subtract built from one shared 4-bit ripple-carry
//             slice, processing one nibble per clock, LS nibble first.
//             Latency NIB+1 cycles from accept to done; one op per NIB+2.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - slave side of nibble_serial_adder_ctrl_if
//  Params   : WIDTH - operand width, multiple of 4, at least 4
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave   bus
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // already inverted for subtraction
  logic [WIDTH-1:0] work;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             overflow_q;

  // Shared 4-bit slice and the work word with the current nibble merged in
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_co;
  logic             msb_cin;
  logic [WIDTH-1:0] work_next;

  always_comb begin
    slice_a              = a_reg[4*idx +: 4];
    slice_b              = b_reg[4*idx +: 4];
    {slice_co, slice_s}  = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_reg};
    // Carry into bit 3 of this slice; only meaningful on the last nibble,
    // where it is the carry into the word MSB used for signed overflow.
    msb_cin              = slice_a[3] ^ slice_b[3] ^ slice_s[3];
    work_next            = work;
    work_next[4*idx +: 4] = slice_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      work       <= '0;
      carry_reg  <= 1'b0;
      idx        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_reg     <= bus.a;
            // Subtraction as a + ~b + 1
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub ? 1'b1 : bus.cin;
            idx       <= '0;
            busy_q    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          work      <= work_next;
          carry_reg <= slice_co;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Results are registered on the edge entering DONE so they are
            // visible together with the done pulse.
            sum_q      <= work_next;
            carry_q    <= slice_co;
            overflow_q <= msb_cin ^ slice_co;
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          idx    <= '0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs WIDTH-bit addition or subtraction by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, least-significant nibble first. It captures operands on a start handshake, carries between nibbles in a register, and presents the registered result, carry and signed overflow with a one-cycle done pulse. It sits between a requesting master and the shared 4-bit adder datapath, trading latency for area on wide operands.

## Interface
- WIDTH, 16, operand width in bits; multiple of 4, minimum 4; NIB = WIDTH/4
- clk_in  input  1  clock; all state changes on rising edge
- rst_n_in  input  1  reset; asynchronous, active-low
- start_in  input  1  request; accepted only in IDLE
- sub_in  input  1  0: a+b+c_in; 1: a-b (c_in ignored); sampled with start_in
- a_in  input  WIDTH  operand A; sampled on accept
- b_in  input  WIDTH  operand B; sampled on accept
- c_in  input  1  carry-in for add; sampled on accept
- busy_out  output  1  high in RUN and DONE
- done_out  output  1  one-cycle pulse; result valid
- sum_out  output  WIDTH  registered result; holds until next done
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow_out  output  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_in=1 accepts. Capture a_in into A reg, b_in (or ~b_in when sub_in=1) into B reg, carry reg = c_in (or 1 when sub_in=1), nibble index = 0. Go to RUN.
- RUN: the 4-bit adder slice receives A[4*idx+:4], B[4*idx+:4], carry reg. Sum nibble written into work reg at idx; carry reg <= slice carry; idx++. When idx == NIB-1 is processed, go to DONE.
- At the last nibble also record carry into bit WIDTH-1: cin_msb = A[W-1]^B[W-1]^S[W-1] (B after inversion).
- DONE: sum_out <= work reg, carry_out <= final carry, overflow_out <= cin_msb ^ final carry, done_out=1 for this cycle only. Next state IDLE.
- start_in in RUN or DONE is ignored; no queuing. Requester must re-assert in IDLE.
- Operands a_in/b_in/c_in/sub_in may change freely after acceptance.
- All arithmetic is modulo 2^WIDTH; no saturation.
- WIDTH=4: RUN lasts exactly one cycle.

## Timing
- Reset (async assert, any state): state=IDLE, idx=0, all internal regs 0; busy_out=0, done_out=0, sum_out=0, carry_out=0, overflow_out=0. Deassertion takes effect at the next rising edge.
- start accepted at edge T (state IDLE, start_in=1): busy_out=1 from T+1.
- RUN occupies edges T+1 .. T+NIB; DONE is entered after edge T+NIB; done_out=1 and new sum_out/carry_out/overflow_out visible in cycle after edge T+NIB, i.e. latency NIB+1 cycles from accept to done.
- busy_out falls after the DONE cycle; earliest next accept one cycle later. Throughput: one operation per NIB+2 cycles.
- sum_out, carry_out, overflow_out change only on entry to DONE (or reset); stable otherwise.
- Reset mid-RUN aborts: no done_out pulse, outputs cleared, operation lost.

## Test plan
- WIDTH=16, add 0x1234+0x4321, c_in=0 -> done_out exactly 5 cycles after accept, sum_out=0x5555, carry_out=0, overflow_out=0.
- Add 0xFFFF+0x0001, c_in=0 -> sum_out=0x0000, carry_out=1, overflow_out=0 (carry ripples across all 4 nibbles); 0x7FFF+0x0001 -> 0x8000, carry_out=0, overflow_out=1.
- sub_in=1, 0x0005-0x0007, c_in=1 (ignored) -> sum_out=0xFFFE, carry_out=0, overflow_out=0; 0x8000-0x0001 -> 0x7FFF, carry_out=1, overflow_out=1.
- Pulse start_in every cycle with changing operands -> only IDLE-cycle requests accepted, one done per 6 cycles, each result matches the operands sampled at its accept.
- Assert rst_n_in=0 two cycles into RUN -> all outputs 0 immediately, no done pulse; after release, new 0x0001+0x0002 completes with sum_out=0x0003.
- WIDTH=4 instance, 0xF+0x1, c_in=1 -> done 2 cycles after accept, sum_out=0x1, carry_out=1, overflow_out=0.
